// File: rtl/axi_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_chk_pkg
// Description : Shared error codes, response constants and helpers for the
//               AXI protocol checker.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_chk_pkg;

    typedef enum logic [3:0] {
        ERR_NONE   = 4'd0,
        ERR_RRESP  = 4'd1,
        ERR_BRESP  = 4'd2,
        ERR_RUNEXP = 4'd3,
        ERR_BUNEXP = 4'd4,
        ERR_ROVF   = 4'd5,
        ERR_WOVF   = 4'd6,
        ERR_RTO    = 4'd7,
        ERR_WTO    = 4'd8,
        ERR_ARSTB  = 4'd9,
        ERR_AWSTB  = 4'd10,
        ERR_WSTB   = 4'd11
    } err_code_e;

    localparam logic [1:0] c_resp_slverr = 2'd2;
    localparam logic [1:0] c_resp_decerr = 2'd3;

    // Lowest set code in a raise vector; bit 0 is never a code.
    function automatic logic [3:0] lowest_code(input logic [11:0] vec);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 11; i >= 1; i--) begin
            if (vec[i]) code = 4'(i);
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_chk_if.sv
`default_nettype none
// ============================================================================
// Module      : axiif
// Description : AXI address/response handshake bundle with master, slave and
//               passive monitor views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axiif #(
    parameter int AW   = 32,
    parameter int IDW  = 8,
    parameter int LENW = 8
);
    logic            arvalid, arready;
    logic [AW-1:0]   araddr;
    logic [IDW-1:0]  arid;
    logic [LENW-1:0] arlen;
    logic            rvalid, rready, rlast;
    logic [IDW-1:0]  rid;
    logic [1:0]      rresp;
    logic            awvalid, awready;
    logic [AW-1:0]   awaddr;
    logic [IDW-1:0]  awid;
    logic [LENW-1:0] awlen;
    logic            wvalid, wready, wlast;
    logic [IDW-1:0]  wid;
    logic            bvalid, bready;
    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;

    modport master (
        output arvalid, araddr, arid, arlen, rready,
               awvalid, awaddr, awid, awlen, wvalid, wid, wlast, bready,
        input  arready, rvalid, rid, rresp, rlast, awready, wready,
               bvalid, bid, bresp
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, rready,
               awvalid, awaddr, awid, awlen, wvalid, wid, wlast, bready,
        output arready, rvalid, rid, rresp, rlast, awready, wready,
               bvalid, bid, bresp
    );

    modport mon (
        input arvalid, arready, araddr, arid, arlen,
              rvalid, rready, rid, rresp, rlast,
              awvalid, awready, awaddr, awid, awlen,
              wvalid, wready, wid, wlast,
              bvalid, bready, bid, bresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_chk_chan.sv
`default_nettype none
// ============================================================================
// Module      : axi_chk_chan
// Description : One direction of the checker: outstanding count, timeout and
//               SLVERR/DECERR counters, plus the per-cycle error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_chk_chan
    import axi_chk_pkg::*;
#(
    parameter int OSW  = 4,
    parameter int CNTW = 16,
    parameter int TOW  = 16
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    input  wire logic            i_clr,
    input  wire logic            i_en,
    input  wire logic            i_req,
    input  wire logic            i_cmp,
    input  wire logic            i_beat,
    input  wire logic [1:0]      i_resp,
    input  wire logic [TOW-1:0]  i_cfg_timeout,
    output logic      [OSW-1:0]  o_outstanding,
    output logic      [CNTW-1:0] o_slverr_cnt,
    output logic      [CNTW-1:0] o_decerr_cnt,
    output logic                 o_flag_resp,
    output logic                 o_flag_unexp,
    output logic                 o_flag_ovf,
    output logic                 o_flag_to
);
    localparam logic [OSW-1:0]  c_os_max  = '1;
    localparam logic [CNTW-1:0] c_cnt_max = '1;

    logic [OSW-1:0]  r_os, w_os_nxt;
    logic [TOW-1:0]  r_tcnt, w_t_base, w_t_nxt;
    logic [TOW:0]    w_t_inc;
    logic [CNTW-1:0] r_slv, r_dec, w_slv_base, w_dec_base;
    logic            w_os_empty, w_os_full, w_slv_hit, w_dec_hit, w_t_run, w_t_hit;

    assign w_os_empty = (r_os == '0);
    assign w_os_full  = (r_os == c_os_max);

    // Simultaneous issue and completion cancel out.
    always_comb begin
        w_os_nxt = r_os;
        if (i_req && !i_cmp && !w_os_full)
            w_os_nxt = r_os + 1'b1;
        else if (i_cmp && !i_req && !w_os_empty)
            w_os_nxt = r_os - 1'b1;
    end

    assign w_slv_hit  = i_en & i_beat & (i_resp == c_resp_slverr);
    assign w_dec_hit  = i_en & i_beat & (i_resp == c_resp_decerr);
    assign w_slv_base = i_clr ? '0 : r_slv;
    assign w_dec_base = i_clr ? '0 : r_dec;

    // Timeout reloads 0 on expiry so a stalled bus re-flags every period.
    assign w_t_base = i_clr ? '0 : r_tcnt;
    assign w_t_inc  = {1'b0, w_t_base} + 1'b1;
    assign w_t_run  = !w_os_empty && !i_cmp && (i_cfg_timeout != '0);
    assign w_t_hit  = w_t_run && (w_t_inc >= {1'b0, i_cfg_timeout});
    assign w_t_nxt  = (!w_t_run || w_t_hit) ? '0 : w_t_inc[TOW-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_os   <= '0;
            r_tcnt <= '0;
            r_slv  <= '0;
            r_dec  <= '0;
        end else begin
            r_os   <= w_os_nxt;
            r_tcnt <= w_t_nxt;
            r_slv  <= (w_slv_hit && w_slv_base != c_cnt_max) ? w_slv_base + 1'b1 : w_slv_base;
            r_dec  <= (w_dec_hit && w_dec_base != c_cnt_max) ? w_dec_base + 1'b1 : w_dec_base;
        end
    end

    assign o_outstanding = r_os;
    assign o_slverr_cnt  = r_slv;
    assign o_decerr_cnt  = r_dec;
    assign o_flag_resp   = w_slv_hit | w_dec_hit;
    assign o_flag_unexp  = i_en & i_cmp & w_os_empty;
    assign o_flag_ovf    = i_en & i_req & w_os_full;
    assign o_flag_to     = i_en & w_t_hit;

endmodule
`default_nettype wire

// File: rtl/axi_chk_mon.sv
`default_nettype none
// ============================================================================
// Module      : axi_chk_mon
// Description : Passive AXI protocol/error checker with counters, sticky
//               error bitmap, first-error record and maskable interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_chk_mon
    import axi_chk_pkg::*;
#(
    parameter int AW   = 32,
    parameter int IDW  = 8,
    parameter int LENW = 8,
    parameter int CNTW = 16,
    parameter int OSW  = 4,
    parameter int TOW  = 16
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    axiif.mon                    aximon,
    input  wire logic            cfg_en,
    input  wire logic [TOW-1:0]  cfg_timeout,
    input  wire logic [11:0]     cfg_irqmask,
    input  wire logic            clr,
    output logic      [OSW-1:0]  rd_outstanding,
    output logic      [OSW-1:0]  wr_outstanding,
    output logic      [CNTW-1:0] rd_slverr_cnt,
    output logic      [CNTW-1:0] rd_decerr_cnt,
    output logic      [CNTW-1:0] wr_slverr_cnt,
    output logic      [CNTW-1:0] wr_decerr_cnt,
    output logic      [11:0]     err_vec,
    output logic      [3:0]      first_code,
    output logic      [IDW-1:0]  first_id,
    output logic      [AW-1:0]   first_addr,
    output logic                 irq
);
    if (AW < 1 || IDW < 1 || LENW < 1) begin : g_bad_param
        $error("axi_chk_mon: bus widths must be positive");
    end

    logic w_ar, w_aw, w_rbeat, w_rl, w_b;
    logic w_rd_resp, w_rd_unexp, w_rd_ovf, w_rd_to;
    logic w_wr_resp, w_wr_unexp, w_wr_ovf, w_wr_to;
    logic [11:0]    w_raise, r_err_vec;
    err_code_e      w_code;
    logic [IDW-1:0] w_sel_id, r_first_id;
    logic [AW-1:0]  w_sel_addr, r_first_addr, r_araddr, r_awaddr;
    logic [3:0]     r_first_code;
    logic           r_ar_stall, r_aw_stall, r_w_stall, r_irq;

    assign w_ar    = aximon.arvalid & aximon.arready;
    assign w_aw    = aximon.awvalid & aximon.awready;
    assign w_rbeat = aximon.rvalid & aximon.rready;
    assign w_rl    = w_rbeat & aximon.rlast;
    assign w_b     = aximon.bvalid & aximon.bready;

    axi_chk_chan #(.OSW(OSW), .CNTW(CNTW), .TOW(TOW)) u_rd (
        .clk(clk), .resetn(resetn), .i_clr(clr), .i_en(cfg_en),
        .i_req(w_ar), .i_cmp(w_rl), .i_beat(w_rbeat), .i_resp(aximon.rresp),
        .i_cfg_timeout(cfg_timeout), .o_outstanding(rd_outstanding),
        .o_slverr_cnt(rd_slverr_cnt), .o_decerr_cnt(rd_decerr_cnt),
        .o_flag_resp(w_rd_resp), .o_flag_unexp(w_rd_unexp),
        .o_flag_ovf(w_rd_ovf), .o_flag_to(w_rd_to)
    );

    axi_chk_chan #(.OSW(OSW), .CNTW(CNTW), .TOW(TOW)) u_wr (
        .clk(clk), .resetn(resetn), .i_clr(clr), .i_en(cfg_en),
        .i_req(w_aw), .i_cmp(w_b), .i_beat(w_b), .i_resp(aximon.bresp),
        .i_cfg_timeout(cfg_timeout), .o_outstanding(wr_outstanding),
        .o_slverr_cnt(wr_slverr_cnt), .o_decerr_cnt(wr_decerr_cnt),
        .o_flag_resp(w_wr_resp), .o_flag_unexp(w_wr_unexp),
        .o_flag_ovf(w_wr_ovf), .o_flag_to(w_wr_to)
    );

    always_comb begin
        w_raise             = '0;
        w_raise[ERR_RRESP]  = w_rd_resp;
        w_raise[ERR_BRESP]  = w_wr_resp;
        w_raise[ERR_RUNEXP] = w_rd_unexp;
        w_raise[ERR_BUNEXP] = w_wr_unexp;
        w_raise[ERR_ROVF]   = w_rd_ovf;
        w_raise[ERR_WOVF]   = w_wr_ovf;
        w_raise[ERR_RTO]    = w_rd_to;
        w_raise[ERR_WTO]    = w_wr_to;
        w_raise[ERR_ARSTB]  = cfg_en & r_ar_stall & ~aximon.arvalid;
        w_raise[ERR_AWSTB]  = cfg_en & r_aw_stall & ~aximon.awvalid;
        w_raise[ERR_WSTB]   = cfg_en & r_w_stall  & ~aximon.wvalid;
    end

    assign w_code = err_code_e'(lowest_code(w_raise));

    // Read-side codes report the read ID/address; everything else the write side.
    always_comb begin
        w_sel_id   = '0;
        w_sel_addr = '0;
        case (w_code)
            ERR_NONE: ;
            ERR_RRESP, ERR_RUNEXP, ERR_ROVF, ERR_RTO, ERR_ARSTB: begin
                w_sel_id   = aximon.rid;
                w_sel_addr = r_araddr;
            end
            ERR_WSTB: begin
                w_sel_id   = aximon.wid;
                w_sel_addr = r_awaddr;
            end
            default: begin
                w_sel_id   = aximon.bid;
                w_sel_addr = r_awaddr;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_araddr     <= '0;
            r_awaddr     <= '0;
            r_ar_stall   <= 1'b0;
            r_aw_stall   <= 1'b0;
            r_w_stall    <= 1'b0;
            r_err_vec    <= '0;
            r_first_code <= '0;
            r_first_id   <= '0;
            r_first_addr <= '0;
            r_irq        <= 1'b0;
        end else begin
            if (w_ar) r_araddr <= aximon.araddr;
            if (w_aw) r_awaddr <= aximon.awaddr;
            r_ar_stall <= aximon.arvalid & ~aximon.arready;
            r_aw_stall <= aximon.awvalid & ~aximon.awready;
            r_w_stall  <= aximon.wvalid & ~aximon.wready;
            r_err_vec  <= (clr ? 12'd0 : r_err_vec) | w_raise;
            if (clr || r_first_code == 4'd0) begin
                r_first_code <= w_code;
                r_first_id   <= w_sel_id;
                r_first_addr <= w_sel_addr;
            end
            r_irq <= |(r_err_vec & cfg_irqmask);
        end
    end

    assign err_vec    = r_err_vec;
    assign first_code = r_first_code;
    assign first_id   = r_first_id;
    assign first_addr = r_first_addr;
    assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_axi_chk_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_chk_mon
// Description : Self-checking bench for axi_chk_mon: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_chk_mon;
    localparam int c_osmax  = 15;
    localparam int c_cntmax = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, cfg_en, clr, irq;
    logic [15:0] cfg_timeout;
    logic [11:0] cfg_irqmask, err_vec;
    logic [3:0]  rd_outstanding, wr_outstanding, first_code;
    logic [15:0] rd_slverr_cnt, rd_decerr_cnt, wr_slverr_cnt, wr_decerr_cnt;
    logic [7:0]  first_id;
    logic [31:0] first_addr;

    axiif #(.AW(32), .IDW(8), .LENW(8)) bus ();

    axi_chk_mon #(.AW(32), .IDW(8), .LENW(8), .CNTW(16), .OSW(4), .TOW(16)) dut (
        .clk(clk), .resetn(resetn), .aximon(bus), .cfg_en(cfg_en),
        .cfg_timeout(cfg_timeout), .cfg_irqmask(cfg_irqmask), .clr(clr),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .rd_slverr_cnt(rd_slverr_cnt), .rd_decerr_cnt(rd_decerr_cnt),
        .wr_slverr_cnt(wr_slverr_cnt), .wr_decerr_cnt(wr_decerr_cnt),
        .err_vec(err_vec), .first_code(first_code), .first_id(first_id),
        .first_addr(first_addr), .irq(irq)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          m_ros, m_wos, m_rslv, m_rdec, m_wslv, m_wdec, m_rto, m_wto, m_first;
    logic [11:0] m_err;
    logic [7:0]  m_id;
    logic [31:0] m_addr, m_lar, m_law;
    logic        m_irq;
    bit          m_ars, m_aws, m_ws;

    task automatic model_reset();
        m_ros = 0; m_wos = 0; m_rslv = 0; m_rdec = 0; m_wslv = 0; m_wdec = 0;
        m_rto = 0; m_wto = 0; m_first = 0; m_err = '0; m_id = '0; m_addr = '0;
        m_lar = '0; m_law = '0; m_irq = 1'b0; m_ars = 0; m_aws = 0; m_ws = 0;
    endtask

    // Applies one clock edge worth of rules to the model from the current inputs.
    task automatic model_step();
        bit ar, aw, rb, rl, b;
        logic [11:0] rs;
        int code;
        ar = bus.arvalid && bus.arready;
        aw = bus.awvalid && bus.awready;
        rb = bus.rvalid && bus.rready;
        rl = rb && bus.rlast;
        b  = bus.bvalid && bus.bready;
        rs = '0;
        m_irq = |(m_err & cfg_irqmask);
        if (clr) begin
            m_rslv = 0; m_rdec = 0; m_wslv = 0; m_wdec = 0; m_rto = 0; m_wto = 0;
            m_err = '0; m_first = 0; m_id = '0; m_addr = '0;
        end
        if (cfg_en) begin
            if (rb && bus.rresp == 2'd2) begin rs[1] = 1; if (m_rslv < c_cntmax) m_rslv++; end
            if (rb && bus.rresp == 2'd3) begin rs[1] = 1; if (m_rdec < c_cntmax) m_rdec++; end
            if (b && bus.bresp == 2'd2)  begin rs[2] = 1; if (m_wslv < c_cntmax) m_wslv++; end
            if (b && bus.bresp == 2'd3)  begin rs[2] = 1; if (m_wdec < c_cntmax) m_wdec++; end
            if (rl && m_ros == 0) rs[3] = 1;
            if (b && m_wos == 0) rs[4] = 1;
            if (ar && m_ros == c_osmax) rs[5] = 1;
            if (aw && m_wos == c_osmax) rs[6] = 1;
            if (m_ars && !bus.arvalid) rs[9] = 1;
            if (m_aws && !bus.awvalid) rs[10] = 1;
            if (m_ws && !bus.wvalid) rs[11] = 1;
        end
        if (m_ros == 0 || rl || cfg_timeout == 0) m_rto = 0;
        else begin
            m_rto++;
            if (m_rto >= int'(cfg_timeout)) begin if (cfg_en) rs[7] = 1; m_rto = 0; end
        end
        if (m_wos == 0 || b || cfg_timeout == 0) m_wto = 0;
        else begin
            m_wto++;
            if (m_wto >= int'(cfg_timeout)) begin if (cfg_en) rs[8] = 1; m_wto = 0; end
        end
        if (ar && !rl) m_ros = (m_ros < c_osmax) ? m_ros + 1 : m_ros;
        else if (rl && !ar && m_ros > 0) m_ros--;
        if (aw && !b) m_wos = (m_wos < c_osmax) ? m_wos + 1 : m_wos;
        else if (b && !aw && m_wos > 0) m_wos--;
        m_err = m_err | rs;
        if (m_first == 0 && rs != 0) begin
            code = 0;
            for (int i = 11; i >= 1; i--) if (rs[i]) code = i;
            m_first = code;
            if (code % 2 == 1 && code != 11) begin m_id = bus.rid; m_addr = m_lar; end
            else if (code == 11) begin m_id = bus.wid; m_addr = m_law; end
            else begin m_id = bus.bid; m_addr = m_law; end
        end
        if (ar) m_lar = bus.araddr;
        if (aw) m_law = bus.awaddr;
        m_ars = bus.arvalid && !bus.arready;
        m_aws = bus.awvalid && !bus.awready;
        m_ws  = bus.wvalid && !bus.wready;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.arvalid = 0; bus.arready = 0; bus.rvalid = 0; bus.rready = 0;
        bus.rlast = 0; bus.rresp = 0; bus.awvalid = 0; bus.awready = 0;
        bus.wvalid = 0; bus.wready = 0; bus.wlast = 0; bus.bvalid = 0;
        bus.bready = 0; bus.bresp = 0; clr = 0;
    endtask

    task automatic test_reset();
        resetn = 0; cfg_en = 1; cfg_timeout = 0; cfg_irqmask = 0;
        idle();
        bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.rid = 0;
        bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.wid = 0; bus.bid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_outstanding !== 4'd0) begin failures++; $display("FAIL reset_rd_os got=%0d exp=0", rd_outstanding); end
        checks++; if (err_vec !== 12'd0) begin failures++; $display("FAIL reset_err_vec got=%0h exp=0", err_vec); end
        checks++; if (first_code !== 4'd0 || irq !== 1'b0) begin failures++; $display("FAIL reset_first_irq got=%0d/%0b exp=0/0", first_code, irq); end
        checks++; if (wr_decerr_cnt !== 16'd0) begin failures++; $display("FAIL reset_wr_dec got=%0d exp=0", wr_decerr_cnt); end
        @(negedge clk) resetn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_outstanding();
        bus.arready = 1; bus.arvalid = 1;
        for (int k = 1; k <= 3; k++) begin
            bus.araddr = 32'h100 * k;
            cyc();
            checks++; if (rd_outstanding !== 4'(k)) begin failures++; $display("FAIL os_inc got=%0d exp=%0d", rd_outstanding, k); end
        end
        bus.arvalid = 0; bus.rvalid = 1; bus.rready = 1; bus.rlast = 1; bus.rresp = 0;
        for (int k = 2; k >= 0; k--) begin
            cyc();
            checks++; if (rd_outstanding !== 4'(k)) begin failures++; $display("FAIL os_dec got=%0d exp=%0d", rd_outstanding, k); end
        end
        idle(); cyc();
        checks++; if (err_vec !== 12'd0) begin failures++; $display("FAIL os_noerr got=%0h exp=0", err_vec); end
    endtask

    task automatic test_bresp();
        clr = 1; cyc(); clr = 0;
        cfg_irqmask = 12'h004;
        bus.awvalid = 1; bus.awready = 1; bus.awaddr = 32'h1000; cyc();
        bus.awvalid = 0; bus.bvalid = 1; bus.bready = 1; bus.bresp = 2'd3; bus.bid = 8'd5; cyc();
        idle();
        checks++; if (wr_decerr_cnt !== 16'd1) begin failures++; $display("FAIL bresp_cnt got=%0d exp=1", wr_decerr_cnt); end
        checks++; if (err_vec !== 12'h004) begin failures++; $display("FAIL bresp_vec got=%0h exp=004", err_vec); end
        checks++; if (first_code !== 4'd2 || first_id !== 8'd5) begin failures++; $display("FAIL bresp_first got=%0d/%0d exp=2/5", first_code, first_id); end
        checks++; if (first_addr !== 32'h1000) begin failures++; $display("FAIL bresp_addr got=%0h exp=1000", first_addr); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL bresp_irq_lag got=%0b exp=0", irq); end
        cyc();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL bresp_irq got=%0b exp=1", irq); end
        cfg_irqmask = 0;
    endtask

    task automatic test_timeout();
        clr = 1; cyc(); clr = 0;
        cfg_timeout = 16'd10;
        bus.arvalid = 1; bus.arready = 1; bus.araddr = 32'h2000; cyc();
        idle();
        repeat (9) cyc();
        checks++; if (err_vec[7] !== 1'b0) begin failures++; $display("FAIL to_early got=%0b exp=0", err_vec[7]); end
        cyc();
        checks++; if (err_vec[7] !== 1'b1) begin failures++; $display("FAIL to_fire got=%0b exp=1", err_vec[7]); end
        checks++; if (first_code !== 4'd7 || first_addr !== 32'h2000) begin failures++; $display("FAIL to_first got=%0d/%0h exp=7/2000", first_code, first_addr); end
        bus.rvalid = 1; bus.rready = 1; bus.rlast = 1; cyc();
        idle(); cfg_timeout = 0; cyc();
        checks++; if (rd_outstanding !== 4'd0) begin failures++; $display("FAIL to_drain got=%0d exp=0", rd_outstanding); end
    endtask

    task automatic test_valid_drop();
        clr = 1; cyc(); clr = 0;
        bus.arvalid = 1; bus.arready = 0; bus.araddr = 32'h5555; cyc();
        bus.arvalid = 0; cyc();
        checks++; if (err_vec !== 12'h200 || first_code !== 4'd9) begin failures++; $display("FAIL arstb got=%0h/%0d exp=200/9", err_vec, first_code); end
    endtask

    task automatic test_unexp_resp();
        clr = 1; cyc(); clr = 0;
        bus.rvalid = 1; bus.rready = 1; bus.rlast = 1; bus.rresp = 2'd2; bus.rid = 8'd3; cyc();
        idle();
        checks++; if (err_vec !== 12'h00A) begin failures++; $display("FAIL unexp_vec got=%0h exp=00a", err_vec); end
        checks++; if (first_code !== 4'd1 || first_id !== 8'd3) begin failures++; $display("FAIL unexp_first got=%0d/%0d exp=1/3", first_code, first_id); end
        checks++; if (rd_slverr_cnt !== 16'd1 || rd_outstanding !== 4'd0) begin failures++; $display("FAIL unexp_cnt got=%0d/%0d exp=1/0", rd_slverr_cnt, rd_outstanding); end
    endtask

    task automatic test_clr_coincident();
        bus.awvalid = 1; bus.awready = 1; bus.awaddr = 32'h3000; cyc();
        bus.awvalid = 0; bus.bvalid = 1; bus.bready = 1; bus.bresp = 2'd2; bus.bid = 8'd7; clr = 1; cyc();
        idle();
        checks++; if (wr_slverr_cnt !== 16'd1) begin failures++; $display("FAIL clr_wslv got=%0d exp=1", wr_slverr_cnt); end
        checks++; if (rd_slverr_cnt !== 16'd0 || rd_decerr_cnt !== 16'd0 || wr_decerr_cnt !== 16'd0) begin failures++; $display("FAIL clr_others got=%0d/%0d/%0d exp=0/0/0", rd_slverr_cnt, rd_decerr_cnt, wr_decerr_cnt); end
        checks++; if (err_vec !== 12'h004 || first_code !== 4'd2) begin failures++; $display("FAIL clr_vec got=%0h/%0d exp=004/2", err_vec, first_code); end
        checks++; if (first_id !== 8'd7 || first_addr !== 32'h3000) begin failures++; $display("FAIL clr_rec got=%0d/%0h exp=7/3000", first_id, first_addr); end
    endtask

    task automatic test_overflow();
        clr = 1; cyc(); clr = 0;
        bus.arvalid = 1; bus.arready = 1; bus.araddr = 32'h40;
        repeat (15) cyc();
        checks++; if (rd_outstanding !== 4'd15 || err_vec[5] !== 1'b0) begin failures++; $display("FAIL ovf_full got=%0d/%0b exp=15/0", rd_outstanding, err_vec[5]); end
        cyc();
        checks++; if (rd_outstanding !== 4'd15 || err_vec[5] !== 1'b1 || first_code !== 4'd5) begin failures++; $display("FAIL ovf_sat got=%0d/%0b/%0d exp=15/1/5", rd_outstanding, err_vec[5], first_code); end
        bus.arvalid = 0; bus.rvalid = 1; bus.rready = 1; bus.rlast = 1;
        repeat (15) cyc();
        idle();
        checks++; if (rd_outstanding !== 4'd0 || err_vec[3] !== 1'b0) begin failures++; $display("FAIL ovf_drain got=%0d/%0b exp=0/0", rd_outstanding, err_vec[3]); end
    endtask

    task automatic test_reset_midburst();
        cfg_irqmask = 12'hFFF;
        bus.arvalid = 1; bus.arready = 1; repeat (2) cyc();
        idle();
        #3;
        resetn = 0;
        #1;
        checks++; if (rd_outstanding !== 4'd0 || err_vec !== 12'd0 || irq !== 1'b0) begin failures++; $display("FAIL rst_mid got=%0d/%0h/%0b exp=0/0/0", rd_outstanding, err_vec, irq); end
        checks++; if (first_code !== 4'd0 || first_addr !== 32'd0) begin failures++; $display("FAIL rst_mid_rec got=%0d/%0h exp=0/0", first_code, first_addr); end
        model_reset();
        @(negedge clk) resetn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        cfg_en = 1;
        cfg_timeout = 16'($urandom_range(4, 12));
        cfg_irqmask = 12'($urandom);
        for (int i = 0; i < 800; i++) begin
            bus.arvalid = ($urandom_range(0, 2) == 0); bus.arready = 1'($urandom);
            bus.araddr = $urandom; bus.arid = 8'($urandom);
            bus.rvalid = ($urandom_range(0, 2) == 0); bus.rready = 1'($urandom);
            bus.rlast = 1'($urandom); bus.rid = 8'($urandom);
            bus.rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            bus.awvalid = ($urandom_range(0, 2) == 0); bus.awready = 1'($urandom);
            bus.awaddr = $urandom; bus.awid = 8'($urandom);
            bus.wvalid = ($urandom_range(0, 2) == 0); bus.wready = 1'($urandom);
            bus.wid = 8'($urandom); bus.wlast = 1'($urandom);
            bus.bvalid = ($urandom_range(0, 2) == 0); bus.bready = 1'($urandom);
            bus.bid = 8'($urandom);
            bus.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            clr = ($urandom_range(0, 47) == 0);
            if ($urandom_range(0, 99) == 0) cfg_en = ~cfg_en;
            if ($urandom_range(0, 199) == 0) cfg_timeout = 16'($urandom_range(0, 12));
            cyc();
            checks++; if (rd_outstanding !== 4'(m_ros)) begin failures++; $display("FAIL rnd_rd_os i=%0d got=%0d exp=%0d", i, rd_outstanding, m_ros); end
            checks++; if (wr_outstanding !== 4'(m_wos)) begin failures++; $display("FAIL rnd_wr_os i=%0d got=%0d exp=%0d", i, wr_outstanding, m_wos); end
            checks++; if (rd_slverr_cnt !== 16'(m_rslv)) begin failures++; $display("FAIL rnd_rslv i=%0d got=%0d exp=%0d", i, rd_slverr_cnt, m_rslv); end
            checks++; if (rd_decerr_cnt !== 16'(m_rdec)) begin failures++; $display("FAIL rnd_rdec i=%0d got=%0d exp=%0d", i, rd_decerr_cnt, m_rdec); end
            checks++; if (wr_slverr_cnt !== 16'(m_wslv)) begin failures++; $display("FAIL rnd_wslv i=%0d got=%0d exp=%0d", i, wr_slverr_cnt, m_wslv); end
            checks++; if (wr_decerr_cnt !== 16'(m_wdec)) begin failures++; $display("FAIL rnd_wdec i=%0d got=%0d exp=%0d", i, wr_decerr_cnt, m_wdec); end
            checks++; if (err_vec !== m_err) begin failures++; $display("FAIL rnd_err_vec i=%0d got=%0h exp=%0h", i, err_vec, m_err); end
            checks++; if (first_code !== 4'(m_first)) begin failures++; $display("FAIL rnd_first_code i=%0d got=%0d exp=%0d", i, first_code, m_first); end
            checks++; if (first_id !== m_id) begin failures++; $display("FAIL rnd_first_id i=%0d got=%0h exp=%0h", i, first_id, m_id); end
            checks++; if (first_addr !== m_addr) begin failures++; $display("FAIL rnd_first_addr i=%0d got=%0h exp=%0h", i, first_addr, m_addr); end
            checks++; if (irq !== m_irq) begin failures++; $display("FAIL rnd_irq i=%0d got=%0b exp=%0b", i, irq, m_irq); end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_outstanding();
        test_bresp();
        test_timeout();
        test_valid_drop();
        test_unexp_resp();
        test_clr_coincident();
        test_overflow();
        test_reset_midburst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_chk_mon.md
# axi_chk_mon

Parametrised AXI protocol and error checker. It is the successor to the display-only AXI/AHB bus monitors. It attaches passively to an `axiif.mon` modport and does the following:
- tracks outstanding read and write transactions;
- counts SLVERR and DECERR responses per direction;
- detects response timeouts, unexpected responses, counter overflow and VALID-drop violations;
- keeps a sticky error bitmap, a first-error record and a maskable interrupt.

It sits beside any AXI master/slave pair in the SoC and in testbenches. It never drives the bus.

## Interface
Parameters:
- AW, 32, address width of the monitored bus
- IDW, 8, ID width
- LENW, 8, burst length width
- CNTW, 16, width of the response-error counters
- OSW, 4, width of the outstanding-transaction counters
- TOW, 16, width of the timeout counter and threshold

Ports:
- clk  in  1  bus clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- aximon  in  axiif.mon  monitored AXI bus, parameters matched to AW/IDW/LENW
- cfg_en  in  1  enables error detection and counting
- cfg_timeout  in  TOW  timeout threshold in cycles; 0 disables the timeout check
- cfg_irqmask  in  12  per-error-code interrupt enable; bit 0 unused
- clr  in  1  single-cycle clear of the counters and error state
- rd_outstanding  out  OSW  outstanding read bursts
- wr_outstanding  out  OSW  outstanding write bursts
- rd_slverr_cnt, rd_decerr_cnt, wr_slverr_cnt, wr_decerr_cnt  out  CNTW  response-error counters
- err_vec  out  12  sticky bitmap, one bit per error code
- first_code  out  4  code of the first recorded error
- first_id  out  IDW  ID of the first recorded error
- first_addr  out  AW  address captured with the first recorded error
- irq  out  1  equals |(err_vec & cfg_irqmask), registered

## Operation
Handshakes are defined as:
- AR = arvalid&arready
- AW = awvalid&awready
- Rl = rvalid&rready&rlast
- B = bvalid&bready

Outstanding counters:
- rd_outstanding increments on AR and decrements on Rl; both in the same cycle leaves it unchanged.
- wr_outstanding uses AW and B the same way.
- An Rl with rd_outstanding==0 raises RUNEXP (3); B with wr_outstanding==0 raises BUNEXP (4). The counter stays at 0.
- AR at 2^OSW−1 raises ROVF (5); AW at 2^OSW−1 raises WOVF (6). The counter saturates.
- The counters run regardless of cfg_en and are not affected by clr.

Response checks:
- Any R beat with rvalid&rready and rresp==2 (SLVERR) or rresp==3 (DECERR) raises RRESP (1) and increments the matching rd counter.
- B handshake with bresp==2 or 3 raises BRESP (2) and increments the matching wr counter.
- Counters saturate at all-ones.

Timeout, per direction:
- The counter increments each cycle that outstanding!=0, cfg_timeout!=0 and no completion handshake (Rl or B) occurs.
- It returns to 0 on a completion handshake, or when outstanding==0.
- On reaching cfg_timeout it raises RTO (7) or WTO (8) and reloads 0, so a stalled bus repeats the flag once per period.

VALID stability:
- If xvalid&~xready is seen in cycle n and ~xvalid in n+1, the block raises ARSTB (9), AWSTB (10) or WSTB (11).

Error recording:
- With cfg_en=0, no error is raised and no error counter moves.
- Every raised code sets err_vec[code].
- The first raised error after reset or clr loads first_code, first_id and first_addr. If several codes are raised in one cycle, the lowest code wins.
- ID and address per code:
  - codes 1, 3, 5, 7, 9: rid and the last accepted araddr
  - codes 2, 4, 6, 8, 10: bid and the last accepted awaddr
  - code 11: wid and the last accepted awaddr
- first_code==0 means no error recorded.

Clear:
- clr zeroes the error counters, err_vec, the first-error record and both timeout counters.
- An event in the same cycle as clr takes effect after the clear: counter = 1, bit set, record loaded.

## Timing
- All outputs are registered. Each output reflects a handshake one cycle after the clk edge that samples it.
- irq follows err_vec by one further cycle.
- On resetn low, all outputs, counters, the timeout counters and the captured-address registers go to 0 immediately. An assertion mid-burst simply discards tracking state.
- No combinational path runs from aximon to any output.

## Structure
- Package axi_chk_pkg holds:
  - the 4-bit error-code enum, with values 0–11 as listed above;
  - the resp constants SLVERR=2 and DECERR=3.
- Sub-module axi_chk_chan is instantiated twice, once for read and once for write. Each instance contains:
  - the outstanding counter with overflow/underflow flags;
  - the timeout counter;
  - the two resp counters.
- The top level contains the VALID-stability checks, the address capture, error arbitration, err_vec and irq.

## Test plan
- Three AR handshakes, then three Rl beats → rd_outstanding goes 1, 2, 3, then 2, 1, 0; no errors.
- B with bresp=3 and bid=5 after AW at 0x1000, with cfg_en=1 → wr_decerr_cnt=1, err_vec[2]=1, first_code=2, first_id=5, first_addr=0x1000; irq=1 when cfg_irqmask[2]=1.
- cfg_timeout=10, one AR issued and no R returned → RTO at cycle 10 after the AR; timeout counter restarts; first_code=7.
- arvalid=1, arready=0, then arvalid=0 → err_vec[9]=1.
- Rl with rd_outstanding=0 in the same cycle as rresp=2 → err_vec bits 1 and 3 set, first_code=1, rd_slverr_cnt=1.
- clr coincident with a B SLVERR → wr_slverr_cnt=1, other counters 0; resetn asserted mid-burst → all outputs 0 immediately.
